onehot_decode_sequencer: RTL

Registered, parametrised N-to-2^N one-hot decoder with a built-in sequencer. It generalises the combinational 3-to-8 decoder in two ways: registered outputs with a start/busy/done handshake, and a scan mode that walks the one-hot output across every line with a programmable dwell. It sits between control logic and banks of select/strobe lines (row enables, chip selects, LED/test-point scan), so a single start pulse drives either one timed strobe or a full sweep.

---
 rtl/onehot_decode_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/onehot_decode_sequencer.sv
// Registered N-to-2^N one-hot decoder with a start/busy/done handshake.
// Drives either one timed strobe or a full wrap-around scan with programmable dwell.
module onehot_decode_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      index,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_N = 1 << SEL_W;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
    logic [SEL_W-1:0]     scnt_q, scnt_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [OUT_N-1:0]     y_q, y_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    function automatic logic [OUT_N-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            dwell_q <= '0;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                y_d    = '0;
                busy_d = 1'b0;
                if (enable && start) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    dwell_d = dwell;
                    idx_d   = sel;
                    dcnt_d  = '0;
                    scnt_d  = '0;
                    y_d     = onehot(sel);
                    busy_d  = 1'b1;
                end
            end
            ACTIVE: begin
                if (!enable) begin
                    // Blanked cycles freeze everything and do not consume dwell.
                    y_d = '0;
                end else begin
                    y_d = onehot(idx_q);
                    if (dcnt_q != dwell_q) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end else if (!mode_q || scnt_q == '1) begin
                        state_d = IDLE;
                        y_d     = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        scnt_d = scnt_q + 1'b1;
                        dcnt_d = '0;
                        y_d    = onehot(idx_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign y     = y_q;
    assign index = idx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
